// File: rtl/cc_cond_unit.sv
// rtl/cc_cond_unit.sv - Y86-64 condition-code register and jXX/cmovXX condition evaluator
module cc_cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] cc_in,
  input  logic       set_cc,
  input  logic       suppress,
  input  logic       cond_valid,
  input  logic [3:0] ifun,
  input  logic       m_stall,
  input  logic       m_bubble,
  output logic [2:0] cc_q,
  output logic       cnd,
  output logic       cond_err,
  output logic       M_Cnd
);

  // Condition select encodings (ifun field of jXX / cmovXX)
  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  // Flags come out of reset as "result was zero"
  localparam logic [2:0] CC_RESET = 3'b100;

  logic [2:0] cc_d;
  logic       m_cnd_d;
  logic       m_cnd_q;
  logic       zf;
  logic       lt;

  // Only the stored flags are used, so a jXX issued alongside an OPq sees the older flags
  assign zf = cc_q[2];
  assign lt = cc_q[1] ^ cc_q[0];

  // Evaluate the selected condition; out-of-range selects are forced false and flagged
  always_comb begin
    cnd      = 1'b0;
    cond_err = 1'b0;
    if (cond_valid) begin
      case (ifun)
        C_ALWAYS: cnd = 1'b1;
        C_LE:     cnd = lt | zf;
        C_L:      cnd = lt;
        C_E:      cnd = zf;
        C_NE:     cnd = ~zf;
        C_GE:     cnd = ~lt;
        C_G:      cnd = ~lt & ~zf;
        default:  cond_err = 1'b1;
      endcase
    end
  end

  // Capture ALU flags for an OPq unless an exception downstream blocks the update
  always_comb begin
    cc_d = cc_q;
    if (set_cc && !suppress) begin
      cc_d = cc_in;
    end
  end

  // M-stage condition register next value; a bubble outranks a stall
  always_comb begin
    m_cnd_d = cnd;
    if (m_bubble) begin
      m_cnd_d = 1'b0;
    end else if (m_stall) begin
      m_cnd_d = m_cnd_q;
    end
  end

  // State update with synchronous reset overriding every other control
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_q    <= CC_RESET;
      m_cnd_q <= 1'b0;
    end else begin
      cc_q    <= cc_d;
      m_cnd_q <= m_cnd_d;
    end
  end

  assign M_Cnd = m_cnd_q;

endmodule

// File: tb/tb_cc_cond_unit.sv
// tb/tb_cc_cond_unit.sv - self-checking bench for cc_cond_unit with a behavioural flag model
module tb_cc_cond_unit;

  logic       clk;
  logic       reset;
  logic [2:0] cc_in;
  logic       set_cc;
  logic       suppress;
  logic       cond_valid;
  logic [3:0] ifun;
  logic       m_stall;
  logic       m_bubble;
  logic [2:0] cc_q;
  logic       cnd;
  logic       cond_err;
  logic       M_Cnd;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [2:0] mdl_cc;
  logic       mdl_m;
  bit         mdl_ok = 0;

  // Hand-derived truth table: bit v of entry f is cnd for flags v={ZF,SF,OF}
  logic [7:0] tt [7];

  cc_cond_unit dut (
    .clk        (clk),
    .reset      (reset),
    .cc_in      (cc_in),
    .set_cc     (set_cc),
    .suppress   (suppress),
    .cond_valid (cond_valid),
    .ifun       (ifun),
    .m_stall    (m_stall),
    .m_bubble   (m_bubble),
    .cc_q       (cc_q),
    .cnd        (cnd),
    .cond_err   (cond_err),
    .M_Cnd      (M_Cnd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {err, cnd}: signed-compare semantics of the Y86 condition names
  function automatic logic [1:0] model_eval(input logic [2:0] cc, input logic [3:0] f, input logic v);
    logic zero, less;
    zero = cc[2];
    less = (cc[1] != cc[0]);
    if (!v) return 2'b00;
    case (f)
      4'd0: return 2'b01;
      4'd1: return {1'b0, less || zero};
      4'd2: return {1'b0, less};
      4'd3: return {1'b0, zero};
      4'd4: return {1'b0, !zero};
      4'd5: return {1'b0, !less};
      4'd6: return {1'b0, !less && !zero};
      default: return 2'b10;
    endcase
  endfunction

  // Model update on each edge
  always @(posedge clk) begin
    logic [1:0] ev;
    if (reset) begin
      mdl_cc = 3'b100;
      mdl_m  = 1'b0;
      mdl_ok = 1;
    end else begin
      if (m_stall && m_bubble)
        $display("[TB] warning: m_stall and m_bubble high together at %0t", $time);
      ev = model_eval(mdl_cc, ifun, cond_valid);
      if (m_bubble)      mdl_m = 1'b0;
      else if (!m_stall) mdl_m = ev[0];
      if (set_cc && !suppress) mdl_cc = cc_in;
    end
  end

  // Compare process: all outputs against the model every cycle once reset has been seen
  always @(negedge clk) begin
    logic [1:0] ev;
    if (mdl_ok) begin
      ev = model_eval(mdl_cc, ifun, cond_valid);
      check("model_cc_q", {5'd0, cc_q}, {5'd0, mdl_cc});
      check("model_M_Cnd", {7'd0, M_Cnd}, {7'd0, mdl_m});
      check("model_cnd", {7'd0, cnd}, {7'd0, ev[0]});
      check("model_cond_err", {7'd0, cond_err}, {7'd0, ev[1]});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    set_cc = 0; suppress = 0; cond_valid = 0; ifun = 0; m_stall = 0; m_bubble = 0;
  endtask

  initial begin
    logic [3:0] flist [9];
    tt = '{8'hFF, 8'hF6, 8'h66, 8'hF0, 8'h0F, 8'h99, 8'h09};
    flist = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15};

    // Reset with a competing flag capture
    idle();
    reset = 1; set_cc = 1; cc_in = 3'b011;
    step();
    step();
    check("reset_cc_q", {5'd0, cc_q}, 8'h04);
    check("reset_M_Cnd", {7'd0, M_Cnd}, 8'h00);
    reset = 0; set_cc = 0; cond_valid = 1; ifun = 4'd3;
    #1;
    check("reset_je_cnd", {7'd0, cnd}, 8'h01);

    // Ordering: jl alongside the OPq sees old flags, next cycle sees new ones
    step();
    set_cc = 1; cc_in = 3'b010; cond_valid = 1; ifun = 4'd2;
    #1;
    check("order_same_cycle_cnd", {7'd0, cnd}, 8'h00);
    step();
    set_cc = 0;
    #1;
    check("order_cc_q", {5'd0, cc_q}, 8'h02);
    check("order_next_cycle_cnd", {7'd0, cnd}, 8'h01);
    step();
    check("order_M_Cnd", {7'd0, M_Cnd}, 8'h01);

    // Condition sweep over all flag values
    for (int v = 0; v < 8; v++) begin
      idle();
      set_cc = 1; cc_in = 3'(v);
      step();
      set_cc = 0;
      for (int k = 0; k < 9; k++) begin
        cond_valid = 1; ifun = flist[k];
        #1;
        if (flist[k] <= 4'd6) begin
          check($sformatf("sweep_cnd_v%0d_f%0d", v, flist[k]), {7'd0, cnd}, {7'd0, tt[flist[k]][v]});
          check($sformatf("sweep_err_v%0d_f%0d", v, flist[k]), {7'd0, cond_err}, 8'h00);
        end else begin
          check($sformatf("sweep_cnd_v%0d_f%0d", v, flist[k]), {7'd0, cnd}, 8'h00);
          check($sformatf("sweep_err_v%0d_f%0d", v, flist[k]), {7'd0, cond_err}, 8'h01);
        end
      end
      cond_valid = 0; ifun = 4'd9;
      #1;
      check("invalid_cnd", {7'd0, cnd}, 8'h00);
      check("invalid_err", {7'd0, cond_err}, 8'h00);
      step();
    end

    // Suppression blocks a flag capture
    idle();
    set_cc = 1; cc_in = 3'b000;
    step();
    set_cc = 1; suppress = 1; cc_in = 3'b100; cond_valid = 1; ifun = 4'd3;
    step();
    set_cc = 0; suppress = 0;
    #1;
    check("suppress_cc_q", {5'd0, cc_q}, 8'h00);
    check("suppress_je_cnd", {7'd0, cnd}, 8'h00);

    // Pipeline control: stall holds, bubble clears, both together clears
    cond_valid = 1; ifun = 4'd0;
    step();
    check("pipe_pre_M_Cnd", {7'd0, M_Cnd}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      m_stall = 1; ifun = (i % 2 == 0) ? 4'd3 : 4'd0;
      step();
      check($sformatf("pipe_stall_hold_%0d", i), {7'd0, M_Cnd}, 8'h01);
    end
    m_stall = 0; m_bubble = 1; ifun = 4'd0;
    step();
    check("pipe_bubble_M_Cnd", {7'd0, M_Cnd}, 8'h00);
    m_bubble = 0;
    step();
    check("pipe_reload_M_Cnd", {7'd0, M_Cnd}, 8'h01);
    m_stall = 1; m_bubble = 1;
    step();
    check("pipe_both_M_Cnd", {7'd0, M_Cnd}, 8'h00);

    // Mid-stream reset overrides capture and stall
    idle();
    set_cc = 1; cc_in = 3'b011; cond_valid = 1; ifun = 4'd0;
    step();
    set_cc = 0;
    step();
    check("midrst_pre_cc_q", {5'd0, cc_q}, 8'h03);
    check("midrst_pre_M_Cnd", {7'd0, M_Cnd}, 8'h01);
    reset = 1; set_cc = 1; cc_in = 3'b001; m_stall = 1;
    step();
    reset = 0; set_cc = 0; m_stall = 0;
    #1;
    check("midrst_cc_q", {5'd0, cc_q}, 8'h04);
    check("midrst_M_Cnd", {7'd0, M_Cnd}, 8'h00);

    // Randomized traffic checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      step();
      reset      = ($urandom_range(0, 59) == 0);
      set_cc     = 1'($urandom_range(0, 1));
      cc_in      = 3'($urandom);
      suppress   = ($urandom_range(0, 3) == 0);
      cond_valid = ($urandom_range(0, 4) != 0);
      ifun       = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
      m_stall    = ($urandom_range(0, 3) == 0);
      m_bubble   = !m_stall && ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) begin
        m_stall = 1; m_bubble = 1;
      end
    end
    idle();
    reset = 0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
